// File: rtl/c_traffic_gen_pkg.sv
// Shared constants for the synthetic traffic generator: FSM encoding and
// the layout of the flit payload.
package c_traffic_gen_pkg;
  typedef enum logic {IDLE = 1'b0, SEND = 1'b1} state_t;

  localparam int SEQ_W  = 8;             // packet sequence number field
  localparam int IDX_W  = 8;             // flit index field
  localparam int DATA_W = SEQ_W + IDX_W; // flit_data = {seq, index}
  localparam int CNT_W  = 8;             // completed-packet counter
endpackage

// File: rtl/c_traffic_gen_lfsr.sv
// Library-style Galois LFSR with parallel load and an optional "complete"
// mode that splices the all-zero state into the sequence.
module c_traffic_gen_lfsr #(
  parameter int               width = 16,
  parameter logic [width-1:0] value = '1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             active,
  input  logic             load,
  input  logic             run,
  input  logic [width-1:0] feedback,
  input  logic             complete,
  input  logic [width-1:0] d,
  output logic [width-1:0] q
);
  logic             fb;
  logic [width-1:0] q_nxt;

  // In complete mode, state 1 steps to 0 and 0 steps to the feedback word.
  assign fb = q[0] ^ (complete && (q[width-1:1] == '0));

  always_comb begin
    q_nxt = q;
    if (load)
      q_nxt = d;
    else if (run)
      q_nxt = {1'b0, q[width-1:1]} ^ (fb ? feedback : '0);
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset)       q <= value;
    else if (active) q <= q_nxt;
  end
endmodule

// File: rtl/c_traffic_gen.sv
// Random packet injector: an LFSR drives the per-idle-cycle injection
// decision and the destination/length of each packet; flits are registered.
module c_traffic_gen
  import c_traffic_gen_pkg::*;
#(
  parameter int                    lfsr_width    = 16,
  parameter int                    rate_width    = 8,
  parameter int                    dest_width    = 4,
  parameter int                    len_width     = 3,
  parameter logic [lfsr_width-1:0] seed          = '1,
  parameter logic [lfsr_width-1:0] lfsr_feedback = lfsr_width'(16'hB400)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  active,
  input  logic                  enable,
  input  logic [rate_width-1:0] rate,
  output logic                  flit_valid,
  input  logic                  flit_ready,
  output logic                  flit_head,
  output logic                  flit_tail,
  output logic [dest_width-1:0] flit_dest,
  output logic [DATA_W-1:0]     flit_data,
  output logic [CNT_W-1:0]      pkt_count
);
  logic                  lfsr_rst;
  logic [lfsr_width-1:0] rnd;
  logic                  unused_rnd;
  logic [rate_width-1:0] rnd_rate;
  logic [dest_width-1:0] rnd_dest;
  logic [len_width-1:0]  rnd_last;

  assign lfsr_rst = ~reset;

  c_traffic_gen_lfsr #(.width(lfsr_width), .value(seed)) u_lfsr (
    .clk      (clk),
    .reset    (lfsr_rst),
    .active   (active),
    .load     (1'b0),
    .run      (1'b1),
    .feedback (lfsr_feedback),
    .complete (1'b0),
    .d        ({lfsr_width{1'b0}}),
    .q        (rnd)
  );

  assign rnd_rate   = rnd[rate_width-1:0];
  assign rnd_dest   = rnd[rate_width +: dest_width];
  assign rnd_last   = rnd[rate_width+dest_width +: len_width];
  assign unused_rnd = ^rnd;

  state_t               state, state_nxt;
  logic [len_width-1:0] idx, idx_nxt, idx_inc, last, last_nxt;
  logic [SEQ_W-1:0]     seq, seq_nxt;
  logic [CNT_W-1:0]     cnt_nxt;
  logic                 valid_nxt, head_nxt, tail_nxt;
  logic [dest_width-1:0] dest_nxt;
  logic [DATA_W-1:0]    data_nxt;
  logic                 go, hs, at_tail;

  assign go      = enable && (rate != '0) && (rnd_rate < rate);
  assign hs      = flit_valid && flit_ready;
  assign at_tail = (idx == last);
  assign idx_inc = idx + 1'b1;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      state <= IDLE;
    else if (active) state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (go) state_nxt = SEND;
      SEND:    if (hs && at_tail) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // Next values of the registered flit outputs; held unless something moves.
  always_comb begin
    idx_nxt   = idx;
    last_nxt  = last;
    seq_nxt   = seq;
    cnt_nxt   = pkt_count;
    valid_nxt = flit_valid;
    head_nxt  = flit_head;
    tail_nxt  = flit_tail;
    dest_nxt  = flit_dest;
    data_nxt  = flit_data;
    case (state)
      IDLE: if (go) begin
        idx_nxt   = '0;
        last_nxt  = rnd_last;
        valid_nxt = 1'b1;
        head_nxt  = 1'b1;
        tail_nxt  = (rnd_last == '0);
        dest_nxt  = rnd_dest;
        data_nxt  = {seq, {IDX_W{1'b0}}};
      end
      SEND: if (hs) begin
        if (at_tail) begin
          valid_nxt = 1'b0;
          head_nxt  = 1'b0;
          tail_nxt  = 1'b0;
          seq_nxt   = seq + 1'b1;
          cnt_nxt   = pkt_count + 1'b1;
        end else begin
          idx_nxt  = idx_inc;
          head_nxt = 1'b0;
          tail_nxt = (idx_inc == last);
          data_nxt = {seq, IDX_W'(idx_inc)};
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      idx        <= '0;
      last       <= '0;
      seq        <= '0;
      pkt_count  <= '0;
      flit_valid <= 1'b0;
      flit_head  <= 1'b0;
      flit_tail  <= 1'b0;
      flit_dest  <= '0;
      flit_data  <= '0;
    end else if (active) begin
      idx        <= idx_nxt;
      last       <= last_nxt;
      seq        <= seq_nxt;
      pkt_count  <= cnt_nxt;
      flit_valid <= valid_nxt;
      flit_head  <= head_nxt;
      flit_tail  <= tail_nxt;
      flit_dest  <= dest_nxt;
      flit_data  <= data_nxt;
    end
  end
endmodule

// File: tb/tb_c_traffic_gen.sv
// Self-checking bench: packet-level reference model plus directed scenarios
// (rate 0, stall, enable drop, 300-packet wrap, reset mid-packet).
module tb_c_traffic_gen;
  logic        clk = 1'b0, reset = 1'b0, active = 1'b0, enable = 1'b0, flit_ready = 1'b0;
  logic [7:0]  rate = 8'h00;
  logic        flit_valid, flit_head, flit_tail;
  logic [3:0]  flit_dest;
  logic [15:0] flit_data;
  logic [7:0]  pkt_count;

  always #5 clk = ~clk;

  c_traffic_gen dut (
    .clk(clk), .reset(reset), .active(active), .enable(enable), .rate(rate),
    .flit_valid(flit_valid), .flit_ready(flit_ready), .flit_head(flit_head),
    .flit_tail(flit_tail), .flit_dest(flit_dest), .flit_data(flit_data),
    .pkt_count(pkt_count)
  );

  int errs = 0, checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errs++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Packet-level model: one "current packet" record plus the random word.
  bit [15:0] m_lfsr;
  bit        m_busy;
  int        m_len, m_pos, m_dest, m_seq, m_pkts, m_done;

  function automatic bit [15:0] lfsr_next(input bit [15:0] q);
    return (q >> 1) ^ (q[0] ? 16'hB400 : 16'h0000);
  endfunction

  task automatic model_reset();
    m_lfsr = 16'hFFFF; m_busy = 0; m_len = 0; m_pos = 0;
    m_dest = 0; m_seq = 0; m_pkts = 0;
  endtask

  task automatic model_step();
    bit [15:0] r;
    r = m_lfsr;
    if (!m_busy) begin
      if (enable && rate != 0 && r[7:0] < rate) begin
        m_busy = 1; m_pos = 0; m_dest = int'(r[11:8]); m_len = int'(r[14:12]) + 1;
      end
    end else if (flit_ready) begin
      if (m_pos == m_len - 1) begin
        m_busy = 0; m_seq = (m_seq + 1) % 256; m_pkts = (m_pkts + 1) % 256; m_done++;
      end else m_pos++;
    end
    m_lfsr = lfsr_next(m_lfsr);
  endtask

  initial begin
    m_done = 0;
    model_reset();
    forever begin
      @(posedge clk or negedge reset);
      if (!reset) model_reset();
      else if (active) model_step();
    end
  end

  // Per-cycle comparison plus a few scenario monitors.
  bit   valid_seen, saw_wrap, saw_single;
  int   hs_cnt;
  logic [7:0] prev_cnt = 8'h00;
  initial begin
    forever begin
      @(negedge clk);
      chk("valid", flit_valid, m_busy);
      chk("pkt_count", pkt_count, m_pkts[7:0]);
      if (m_busy) begin
        chk("head", flit_head, m_pos == 0);
        chk("tail", flit_tail, m_pos == m_len - 1);
        chk("dest", flit_dest, m_dest);
        chk("data", flit_data, {m_seq[7:0], m_pos[7:0]});
      end
      if (flit_valid) valid_seen = 1;
      if (flit_valid && flit_ready) hs_cnt++;
      if (flit_valid && flit_head && flit_tail) begin
        saw_single = 1;
        chk("single_idx", flit_data[7:0], 0);
      end
      if (prev_cnt == 8'hFF && pkt_count == 8'h00) saw_wrap = 1;
      prev_cnt = pkt_count;
    end
  end

  task automatic do_reset();
    @(posedge clk); #1;
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b1;
  endtask

  task automatic wait_first_valid(output int n);
    n = 0;
    while (!flit_valid && n < 100) begin @(posedge clk); #1; n++; end
  endtask

  int n;
  bit found;

  initial begin
    reset = 0; active = 1; enable = 1; rate = 8'h00; flit_ready = 1;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_valid", flit_valid, 0);
    chk("rst_head", flit_head, 0);
    chk("rst_tail", flit_tail, 0);
    chk("rst_dest", flit_dest, 0);
    chk("rst_data", flit_data, 0);
    chk("rst_cnt", pkt_count, 0);

    // rate 0 never injects
    reset = 1; valid_seen = 0;
    repeat (1000) @(posedge clk);
    #1;
    chk("rate0_valid_seen", valid_seen, 0);
    chk("rate0_cnt", pkt_count, 0);

    // random traffic with gating and back-pressure
    repeat (3000) begin
      @(posedge clk); #1;
      enable     = ($urandom_range(0, 3) != 0);
      rate       = 8'($urandom);
      active     = ($urandom_range(0, 7) != 0);
      flit_ready = ($urandom_range(0, 2) != 0);
    end

    // stall on the first flit after reseed: seed FFFF injects on the 5th edge,
    // dest A, length 6
    reset = 0; active = 1; enable = 1; rate = 8'hFF; flit_ready = 0;
    do_reset();
    wait_first_valid(n);
    chk("first_latency", n, 5);
    chk("first_tail", flit_tail, 0);
    repeat (50) begin
      @(posedge clk); #1;
      chk("stall_valid", flit_valid, 1);
      chk("stall_head", flit_head, 1);
      chk("stall_dest", flit_dest, 4'hA);
      chk("stall_data", flit_data, 16'h0000);
    end

    // drop enable during that 6-flit packet: it still completes, nothing follows
    hs_cnt = 0; enable = 0; flit_ready = 1;
    n = 0;
    while (m_busy && n < 100) begin @(posedge clk); #1; n++; end
    chk("drop_done_in_time", n < 100, 1);
    chk("drop_flits", hs_cnt, 6);
    valid_seen = 0;
    repeat (200) @(posedge clk);
    #1;
    chk("drop_no_more", valid_seen, 0);
    chk("drop_cnt", pkt_count, 1);

    // 300 back-to-back packets: counter wraps and lands on 44
    reset = 0; enable = 1; rate = 8'hFF; flit_ready = 1;
    do_reset();
    saw_wrap = 0; saw_single = 0;
    n = m_done;
    for (int c = 0; c < 20000 && (m_done - n) < 300; c++) begin @(posedge clk); #1; end
    chk("pkts_300_done", m_done - n, 300);
    chk("pkts_300_cnt", pkt_count, 44);
    chk("saw_wrap", saw_wrap, 1);
    chk("saw_single", saw_single, 1);

    // reset while index 2 of a 5-flit packet is on the wire
    found = 0;
    for (int c = 0; c < 20000; c++) begin
      @(posedge clk); #1;
      if (m_busy && m_len == 5 && m_pos == 2) begin found = 1; break; end
    end
    chk("found_len5", found, 1);
    reset = 0;
    #1;
    chk("rst_mid_valid", flit_valid, 0);
    chk("rst_mid_cnt", pkt_count, 0);
    @(posedge clk); #1;
    reset = 1;
    wait_first_valid(n);
    chk("post_rst_latency", n, 5);
    chk("post_rst_head", flit_head, 1);
    chk("post_rst_seq", flit_data[15:8], 0);
    chk("post_rst_dest", flit_dest, 4'hA);

    @(negedge clk);
    $display("Result: errors=%0d of %0d checks", errs, checks);
    $finish;
  end
endmodule

// File: doc/c_traffic_gen.md
C_TRAFFIC_GEN -- requirements
Module: c_traffic_gen

Interface
REQ-001 Parameter lfsr_width, default 16: width of the internal pseudo-random state (>= rate_width + dest_width + len_width).
REQ-002 Parameter rate_width, default 8: injection-rate threshold width.
REQ-003 Parameter dest_width, default 4: destination field width.
REQ-004 Parameter len_width, default 3: packet length field width; lengths 1..2^len_width flits.
REQ-005 Parameter seed, default all-ones (lfsr_width bits): random state after reset.
REQ-006 Parameter lfsr_feedback, default 16'hB400 (lfsr_width bits): feedback polynomial.
REQ-007 Port clk  input  1  clock; all state updates on rising edge.
REQ-008 Port reset  input  1  asynchronous, active-low reset (0 = reset asserted).
REQ-009 Port active  input  1  clock-gating hint; no state changes when 0.
REQ-010 Port enable  input  1  permits starting new packets.
REQ-011 Port rate  input  rate_width  injection threshold per idle cycle.
REQ-012 Port flit_valid  output  1  flit offered.
REQ-013 Port flit_ready  input  1  downstream accepts flit.
REQ-014 Port flit_head  output  1  first flit of packet.
REQ-015 Port flit_tail  output  1  last flit of packet.
REQ-016 Port flit_dest  output  dest_width  packet destination.
REQ-017 Port flit_data  output  16  {packet sequence number[7:0], flit index[7:0]}.
REQ-018 Port pkt_count  output  8  completed packets, modulo 256.

Function
REQ-019 Random state SHALL advance one LFSR step every cycle active=1, independent of FSM state.
REQ-020 FSM SHALL have two states, IDLE and SEND.
REQ-021 IDLE: flit_valid=0; move to SEND when enable=1, rate!=0 and rand[rate_width-1:0] < rate.
REQ-022 On IDLE->SEND, SHALL capture dest = rand[rate_width +: dest_width], length = rand[rate_width+dest_width +: len_width] + 1, flit index = 0.
REQ-023 SEND: flit_valid=1; flit_head = (index==0); flit_tail = (index==length-1); single-flit packet asserts both.
REQ-024 flit_valid, flit_dest, flit_data, flit_head, flit_tail SHALL stay stable while flit_valid=1 and flit_ready=0.
REQ-025 Handshake (flit_valid & flit_ready) on a non-tail flit SHALL increment index by 1.
REQ-026 Handshake on tail flit SHALL return to IDLE, increment pkt_count (wrap 255->0), increment sequence number (wrap); no new packet that cycle, so minimum one idle cycle between packets.
REQ-027 Deasserting enable in SEND SHALL NOT abort the packet; packet completes.
REQ-028 Changes of rate SHALL affect only the next IDLE decision.
REQ-029 rate=0 SHALL never inject; rate=2^rate_width-1 injects unless rand low bits equal all-ones.
REQ-030 Outputs SHALL be registered; first flit visible the cycle after the IDLE decision.

Reset
REQ-031 While reset=0: state=IDLE, random state=seed, index=0, sequence=0, pkt_count=0, flit_valid=0, flit_head=0, flit_tail=0, flit_dest=0, flit_data=0.
REQ-032 Reset asserted mid-packet SHALL drop the packet immediately (flit_valid=0 asynchronously); no partial packet resumes after release.
REQ-033 First LFSR step SHALL occur on the first rising edge with reset=1 and active=1.

Structure
REQ-034 FSM state encoding and flit_data field widths SHALL live in the shared constants package.
REQ-035 Random state SHALL be one instance of the library LFSR (load=0, run=1, complete=0, d=0), reset polarity adapted locally.
REQ-036 Size: 120-400 RTL lines.

Verification
REQ-037 rate=0, enable=1, flit_ready=1 for 1000 cycles -> flit_valid never 1, pkt_count=0.
REQ-038 rate=8'hFF, flit_ready=0 for 50 cycles after first flit_valid -> valid, head, dest, data unchanged all 50 cycles.
REQ-039 rate=8'hFF, flit_ready=1, 300 packets -> each packet: one head, one tail, index 0..length-1 contiguous, length 1..8, pkt_count wraps 255->0 then reaches 44.
REQ-040 Single-flit packet (length=1) -> one cycle with head=1 and tail=1, flit_data index 0.
REQ-041 Assert reset=0 during index 2 of a 5-flit packet -> flit_valid=0 same cycle, pkt_count=0; after release, next packet has head=1, sequence 0.
REQ-042 Drop enable during SEND of a 6-flit packet -> all 6 flits delivered, then no further packets.
